// File: rtl/cnn_window_gen.sv
// Sliding-window generator for stride-1, no-padding convolution.
// Buffers KY-1 rows and emits a KX*KY window once per accepted pixel that completes a full in-image window.
module cnn_window_gen #(
    parameter int KX      = 3,
    parameter int KY      = 3,
    parameter int I_FM_BW = 8,
    parameter int IW      = 28,
    parameter int IH      = 28
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_soft_reset,
    input  logic [I_FM_BW-1:0]        i_in_pixel,
    input  logic                      i_in_valid,
    output logic [KX*KY*I_FM_BW-1:0]  o_ot_fmap,
    output logic                      o_ot_valid,
    output logic                      o_ot_frame_done
);

    localparam int CW = (IW > 1) ? $clog2(IW) : 1;
    localparam int RW = (IH > 1) ? $clog2(IH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KY - 1);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               accept;
    logic [I_FM_BW-1:0] line_buf [KY-1][IW];
    logic [I_FM_BW-1:0] win      [KY][KX];
    logic [I_FM_BW-1:0] column   [KY];

    assign accept = i_in_valid && !i_soft_reset;

    // Column entering the window: oldest buffered row on top, live pixel at the bottom.
    always_comb begin
        for (int ky = 0; ky < KY; ky++) begin
            column[ky] = '0;
        end
        for (int ky = 0; ky < KY - 1; ky++) begin
            column[ky] = line_buf[KY-2-ky][col];
        end
        column[KY-1] = i_in_pixel;
    end

    // Line buffer RAM is never cleared; stale contents are masked by the row/col gating.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < KY - 1; k++) begin
                if (k == 0) begin
                    line_buf[k][col] <= i_in_pixel;
                end else begin
                    line_buf[k][col] <= line_buf[k-1][col];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col             <= '0;
            row             <= '0;
            o_ot_valid      <= 1'b0;
            o_ot_frame_done <= 1'b0;
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else if (i_soft_reset) begin
            col             <= '0;
            row             <= '0;
            o_ot_valid      <= 1'b0;
            o_ot_frame_done <= 1'b0;
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    win[ky][kx] <= '0;
                end
            end
        end else begin
            o_ot_valid      <= 1'b0;
            o_ot_frame_done <= 1'b0;
            if (i_in_valid) begin
                for (int ky = 0; ky < KY; ky++) begin
                    for (int kx = 0; kx < KX - 1; kx++) begin
                        win[ky][kx] <= win[ky][kx+1];
                    end
                    win[ky][KX-1] <= column[ky];
                end
                o_ot_valid      <= (row >= ROW_WIN) && (col >= COL_WIN);
                o_ot_frame_done <= (row == ROW_LAST) && (col == COL_LAST);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_comb begin
        o_ot_fmap = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                o_ot_fmap[I_FM_BW*(ky*KX+kx) +: I_FM_BW] = win[ky][kx];
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: a 5x5 instance for directed/random scenarios and a 28x28
// instance for the default-size frame, both checked against an image-array window model.
module tb_cnn_window_gen;

    localparam int SW = 5;
    localparam int SH = 5;
    localparam int BW = 28;
    localparam int BH = 28;
    localparam int WB = 72;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic          s_srst = 1'b0, s_vld = 1'b0;
    logic [7:0]    s_pix = '0;
    logic [WB-1:0] s_fmap;
    logic          s_ov, s_done;

    logic          b_srst = 1'b0, b_vld = 1'b0;
    logic [7:0]    b_pix = '0;
    logic [WB-1:0] b_fmap;
    logic          b_ov, b_done;

    always #5 clk = ~clk;

    cnn_window_gen #(.KX(3), .KY(3), .I_FM_BW(8), .IW(SW), .IH(SH)) dut_s (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(s_srst), .i_in_pixel(s_pix),
        .i_in_valid(s_vld), .o_ot_fmap(s_fmap), .o_ot_valid(s_ov), .o_ot_frame_done(s_done)
    );

    cnn_window_gen #(.KX(3), .KY(3), .I_FM_BW(8), .IW(BW), .IH(BH)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(b_srst), .i_in_pixel(b_pix),
        .i_in_valid(b_vld), .o_ot_fmap(b_fmap), .o_ot_valid(b_ov), .o_ot_frame_done(b_done)
    );

    int checks = 0;
    int failures = 0;

    // Reference: store the frame as an image, cut windows directly out of it.
    int            m_r [2];
    int            m_c [2];
    logic [7:0]    img [2][28][28];
    bit            exp_v, exp_d;
    logic [WB-1:0] exp_w;

    task automatic model_restart(input int id);
        m_r[id] = 0;
        m_c[id] = 0;
    endtask

    task automatic model_accept(input int id, input int w, input int h, input logic [7:0] pix);
        int r = m_r[id];
        int c = m_c[id];
        img[id][r][c] = pix;
        exp_v = (r >= 2) && (c >= 2);
        exp_d = (r == h - 1) && (c == w - 1);
        exp_w = '0;
        if (exp_v) begin
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    exp_w[8*(ky*3+kx) +: 8] = img[id][r-2+ky][c-2+kx];
        end
        m_c[id] = c + 1;
        if (m_c[id] == w) begin
            m_c[id] = 0;
            m_r[id] = (r + 1 == h) ? 0 : r + 1;
        end
    endtask

    task automatic step_s(input logic vld, input logic [7:0] pix, input logic srst);
        s_vld = vld; s_pix = pix; s_srst = srst;
        @(posedge clk); #1;
        s_vld = 1'b0; s_srst = 1'b0;
        exp_v = 1'b0; exp_d = 1'b0;
        if (srst) model_restart(0);
        else if (vld) model_accept(0, SW, SH, pix);
    endtask

    task automatic step_b(input logic vld, input logic [7:0] pix);
        b_vld = vld; b_pix = pix;
        @(posedge clk); #1;
        b_vld = 1'b0;
        exp_v = 1'b0; exp_d = 1'b0;
        if (vld) model_accept(1, BW, BH, pix);
    endtask

    task automatic test_reset();
        int nwin = 0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", s_ov); end
        checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", s_done); end
        checks++; if (s_fmap !== '0) begin failures++; $display("FAIL reset_fmap got %h want 0", s_fmap); end
        reset_n = 1'b1;
        model_restart(0); model_restart(1);
        for (int p = 0; p < 14; p++) begin
            step_s(1'b1, 8'(p + 50), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL pre_reset_valid p=%0d got %b want %b", p, s_ov, exp_v); end
        end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL async_reset_valid got %b want 0", s_ov); end
        checks++; if (s_fmap !== '0) begin failures++; $display("FAIL async_reset_fmap got %h want 0", s_fmap); end
        @(posedge clk); #1 reset_n = 1'b1;
        model_restart(0); model_restart(1);
        for (int p = 0; p < 25; p++) begin
            step_s(1'b1, 8'(p), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL restart_valid p=%0d got %b want %b", p, s_ov, exp_v); end
            checks++; if (s_done !== exp_d) begin failures++; $display("FAIL restart_done p=%0d got %b want %b", p, s_done, exp_d); end
            if (exp_v) begin
                nwin++;
                checks++; if (s_fmap !== exp_w) begin failures++; $display("FAIL restart_fmap p=%0d got %h want %h", p, s_fmap, exp_w); end
            end
        end
        checks++; if (nwin != 9) begin failures++; $display("FAIL restart_count got %0d want 9", nwin); end
    endtask

    task automatic test_full_frame();
        int nwin = 0, ndone = 0;
        logic [WB-1:0] first_w = '0, last_w = '0;
        logic [WB-1:0] first_k = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        logic [WB-1:0] last_k  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
        for (int p = 0; p < 25; p++) begin
            step_s(1'b1, 8'(p), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL full_valid p=%0d got %b want %b", p, s_ov, exp_v); end
            checks++; if (s_done !== exp_d) begin failures++; $display("FAIL full_done p=%0d got %b want %b", p, s_done, exp_d); end
            if (exp_v) begin
                checks++; if (s_fmap !== exp_w) begin failures++; $display("FAIL full_fmap p=%0d got %h want %h", p, s_fmap, exp_w); end
            end
            if (s_ov === 1'b1) begin
                if (nwin == 0) first_w = s_fmap;
                last_w = s_fmap;
                nwin++;
            end
            if (s_done === 1'b1) ndone++;
        end
        checks++; if (nwin != 9) begin failures++; $display("FAIL full_count got %0d want 9", nwin); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL full_done_count got %0d want 1", ndone); end
        checks++; if (first_w !== first_k) begin failures++; $display("FAIL full_first got %h want %h", first_w, first_k); end
        checks++; if (last_w !== last_k) begin failures++; $display("FAIL full_last got %h want %h", last_w, last_k); end
    endtask

    task automatic test_gaps();
        int nwin = 0, ndone = 0;
        for (int p = 0; p < 25; p++) begin
            int g = 0;
            while ($urandom_range(0, 1) == 1 && g < 4) begin
                g++;
                step_s(1'b0, 8'($urandom), 1'b0);
                checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL gap_idle_valid p=%0d got %b want 0", p, s_ov); end
            end
            step_s(1'b1, 8'(p), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL gap_valid p=%0d got %b want %b", p, s_ov, exp_v); end
            checks++; if (s_done !== exp_d) begin failures++; $display("FAIL gap_done p=%0d got %b want %b", p, s_done, exp_d); end
            if (exp_v) begin
                checks++; if (s_fmap !== exp_w) begin failures++; $display("FAIL gap_fmap p=%0d got %h want %h", p, s_fmap, exp_w); end
            end
            if (s_ov === 1'b1) nwin++;
            if (s_done === 1'b1) ndone++;
        end
        checks++; if (nwin != 9) begin failures++; $display("FAIL gap_count got %0d want 9", nwin); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL gap_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_soft_reset();
        int nwin = 0;
        logic [WB-1:0] last_k = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
        logic [WB-1:0] last_w = '0;
        for (int p = 0; p < 8; p++) step_s(1'b1, 8'(200 + p), 1'b0);
        step_s(1'b1, 8'd99, 1'b1);
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL soft_valid got %b want 0", s_ov); end
        checks++; if (s_fmap !== '0) begin failures++; $display("FAIL soft_fmap got %h want 0", s_fmap); end
        for (int p = 0; p < 25; p++) begin
            step_s(1'b1, 8'(p), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL soft_frame_valid p=%0d got %b want %b", p, s_ov, exp_v); end
            checks++; if (s_done !== exp_d) begin failures++; $display("FAIL soft_frame_done p=%0d got %b want %b", p, s_done, exp_d); end
            if (exp_v) begin
                checks++; if (s_fmap !== exp_w) begin failures++; $display("FAIL soft_frame_fmap p=%0d got %h want %h", p, s_fmap, exp_w); end
            end
            if (s_ov === 1'b1) begin nwin++; last_w = s_fmap; end
        end
        checks++; if (nwin != 9) begin failures++; $display("FAIL soft_count got %0d want 9", nwin); end
        checks++; if (last_w !== last_k) begin failures++; $display("FAIL soft_last got %h want %h", last_w, last_k); end
    endtask

    task automatic test_back_to_back();
        int nwin = 0, ndone = 0;
        logic [WB-1:0] f2_k = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};
        logic [WB-1:0] f2_w = '0;
        for (int p = 0; p < 50; p++) begin
            step_s(1'b1, (p < 25) ? 8'(p) : 8'(p - 25 + 100), 1'b0);
            checks++; if (s_ov !== exp_v) begin failures++; $display("FAIL b2b_valid i=%0d got %b want %b", p, s_ov, exp_v); end
            checks++; if (s_done !== exp_d) begin failures++; $display("FAIL b2b_done i=%0d got %b want %b", p, s_done, exp_d); end
            if (exp_v) begin
                checks++; if (s_fmap !== exp_w) begin failures++; $display("FAIL b2b_fmap i=%0d got %h want %h", p, s_fmap, exp_w); end
            end
            if (s_ov === 1'b1) begin
                if (nwin == 9) f2_w = s_fmap;
                nwin++;
            end
            if (s_done === 1'b1) ndone++;
        end
        checks++; if (nwin != 18) begin failures++; $display("FAIL b2b_count got %0d want 18", nwin); end
        checks++; if (ndone != 2) begin failures++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++; if (f2_w !== f2_k) begin failures++; $display("FAIL b2b_frame2_first got %h want %h", f2_w, f2_k); end
    endtask

    task automatic test_defaults();
        int nwin = 0, ndone = 0, bad = 0;
        for (int p = 0; p < BW * BH; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                step_b(1'b0, 8'($urandom));
                checks++; if (b_ov !== 1'b0) begin failures++; $display("FAIL dflt_idle_valid p=%0d got %b want 0", p, b_ov); end
            end
            step_b(1'b1, 8'($urandom));
            checks++;
            if (b_ov !== exp_v || b_done !== exp_d || (exp_v && b_fmap !== exp_w)) begin
                failures++;
                if (bad < 10) $display("FAIL dflt_window p=%0d got v=%b d=%b %h want v=%b d=%b %h", p, b_ov, b_done, b_fmap, exp_v, exp_d, exp_w);
                bad++;
            end
            if (b_ov === 1'b1) nwin++;
            if (b_done === 1'b1) ndone++;
        end
        checks++; if (nwin != 676) begin failures++; $display("FAIL dflt_count got %0d want 676", nwin); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL dflt_done_count got %0d want 1", ndone); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_soft_reset();
        test_back_to_back();
        test_defaults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
